// File: rtl/radio_tx_core_if.sv
// Audio sample handshake between an audio source and the FM transmit core.
interface radio_tx_core_if;
  logic signed [15:0] audio;
  logic               audio_valid;
  logic               audio_ready;

  modport master (output audio, output audio_valid, input audio_ready);
  modport slave  (input audio, input audio_valid, output audio_ready);
endinterface

// File: rtl/radio_tx_core.sv
// FM transmitter: audio holding register, 3-stage CIC interpolator (x R2),
// deviation scaling and carrier phase accumulator driving a 1-bit RF output.
module radio_tx_core #(
  parameter int width_dds = 32,
  parameter int R2        = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_b,
  input  logic                 en_a,
  input  logic [width_dds-1:0] K,
  input  logic [14:0]          Kd,
  radio_tx_core_if.slave       aud,
  output logic                 underrun,
  output logic                 rf
);

  localparam int W    = 16 + $clog2(R2**3);
  localparam int SLSB = $clog2(R2**2);

  genvar gi;

  logic                    r_run;
  logic                    r_full;
  logic                    r_underrun;
  logic                    r_stuff;
  logic                    r_rf;
  logic signed [15:0]      r_hold;
  logic signed [15:0]      r_xprev;
  logic signed [W-1:0]     r_cout;
  logic [width_dds-1:0]    r_dev;
  logic [width_dds-1:0]    r_phase;

  logic                    w_accept;
  logic signed [15:0]      w_x;
  logic signed [W-1:0]     w_up;
  logic signed [15:0]      w_s;
  logic signed [30:0]      w_s_wide;
  logic signed [30:0]      w_kd_wide;
  logic signed [30:0]      w_prod;
  logic [width_dds-1:0]    w_dev;
  logic signed [W-1:0]     w_comb [0:3];
  logic signed [W-1:0]     w_int  [0:2];

  assign aud.audio_ready = ~r_full & r_run;
  assign w_accept        = aud.audio_valid & aud.audio_ready;

  // An empty register at en_a repeats the last consumed sample.
  assign w_x        = r_full ? r_hold : r_xprev;
  assign w_comb[0]  = {{(W-16){w_x[15]}}, w_x};

  for (gi = 0; gi < 3; gi++) begin : g_comb
    logic signed [W-1:0] r_d;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        r_d <= '0;
      else if (en_a)
        r_d <= w_comb[gi];
    end
    assign w_comb[gi+1] = w_comb[gi] - r_d;
  end

  assign w_up     = r_stuff ? r_cout : '0;
  assign w_int[0] = w_up;

  for (gi = 0; gi < 3; gi++) begin : g_int
    logic signed [W-1:0] r_i;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        r_i <= '0;
      else if (en_b)
        r_i <= r_i + w_int[gi];
    end
    if (gi < 2) begin : g_fwd
      assign w_int[gi+1] = r_i;
    end
  end

  // Drop the CIC gain's 2**SLSB part; the residual gain is R2**2 / 2**SLSB.
  assign w_s       = g_int[2].r_i[SLSB+15 -: 16];
  assign w_s_wide  = {{15{w_s[15]}}, w_s};
  assign w_kd_wide = {16'd0, Kd};
  assign w_prod    = w_s_wide * w_kd_wide;
  assign w_dev     = {{(width_dds-31){w_prod[30]}}, w_prod};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run      <= 1'b0;
      r_full     <= 1'b0;
      r_underrun <= 1'b0;
      r_stuff    <= 1'b0;
      r_rf       <= 1'b0;
      r_hold     <= '0;
      r_xprev    <= '0;
      r_cout     <= '0;
      r_dev      <= '0;
      r_phase    <= '0;
    end else begin
      r_run <= 1'b1;

      if (en_a) begin
        r_xprev <= w_x;
        r_cout  <= w_comb[3];
        r_stuff <= 1'b1;
        if (!r_full)
          r_underrun <= 1'b1;
      end else if (en_b) begin
        r_stuff <= 1'b0;
      end

      // Ready is low while full, so accept and consume never collide.
      if (w_accept) begin
        r_hold <= aud.audio;
        r_full <= 1'b1;
      end else if (en_a) begin
        r_full <= 1'b0;
      end

      if (en_b)
        r_dev <= w_dev;

      r_phase <= r_phase + K + r_dev;
      r_rf    <= r_phase[width_dds-1];
    end
  end

  assign underrun = r_underrun;
  assign rf       = r_rf;

endmodule

// File: tb/tb_radio_tx_core.sv
// Scoreboard bench for radio_tx_core: random/directed audio against a
// convolution-based reference of the CIC chain and an exact phase model.
module tb_radio_tx_core;

  localparam int WD   = 32;
  localparam int R2   = 30;
  localparam int NB   = 4;
  localparam int NTAP = 3*R2 - 2;
  localparam int PER  = NB*R2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en_a = 1'b0;
  logic        en_b = 1'b0;
  logic [31:0] K = 32'd0;
  logic [14:0] Kd = 15'd0;
  logic        underrun;
  logic        rf;

  int checks = 0;
  int errors = 0;

  radio_tx_core_if aud_if ();

  radio_tx_core #(.width_dds(WD), .R2(R2)) dut (
    .clk      (clk),
    .reset    (reset),
    .en_b     (en_b),
    .en_a     (en_a),
    .K        (K),
    .Kd       (Kd),
    .aud      (aud_if),
    .underrun (underrun),
    .rf       (rf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        under;
    logic        rf;
    logic [31:0] dev;
  } exp_t;

  exp_t exp_q[$];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, expv);
    end
  endtask

  // Clock enables: en_b every NB clk, en_a on every R2-th en_b, restarted by reset.
  initial begin
    int cb;
    int ca;
    cb = 0;
    ca = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cb = 0; ca = 0; en_a = 1'b0; en_b = 1'b0;
      end else begin
        cb   = (cb + 1) % NB;
        en_b = (cb == 0);
        if (en_b) ca = (ca + 1) % R2;
        en_a = en_b && (ca == 0);
      end
    end
  end

  // Reference model: zero-stuffed base-band sequence convolved with the
  // triple-boxcar impulse response of the CIC, then scaled and accumulated.
  longint      h [0:NTAP-1];
  longint      vq[$];
  bit          m_run, m_full, m_under, m_pend, m_rf, m_rdy, m_acc;
  logic signed [15:0] m_hold, m_xprev, m_pend_x, m_x, m_s;
  logic [31:0] m_phase, m_dev;
  logic [63:0] m_y;

  initial begin
    longint t2 [0:2*R2-2];
    longint y;
    for (int i = 0; i < 2*R2-1; i++) t2[i] = 0;
    for (int i = 0; i < NTAP; i++) h[i] = 0;
    for (int i = 0; i < R2; i++)
      for (int j = 0; j < R2; j++) t2[i+j] += 1;
    for (int i = 0; i < 2*R2-1; i++)
      for (int j = 0; j < R2; j++) h[i+j] += t2[i];
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_run = 0; m_full = 0; m_under = 0; m_pend = 0; m_rf = 0;
        m_hold = 0; m_xprev = 0; m_pend_x = 0; m_phase = 0; m_dev = 0;
        vq.delete();
        repeat (NTAP+3) vq.push_back(0);
      end else begin
        m_rdy   = !m_full && m_run;
        m_acc   = aud_if.audio_valid && m_rdy;
        m_rf    = m_phase[31];
        m_phase = m_phase + K + m_dev;
        if (en_b) begin
          vq.push_front(m_pend ? longint'(m_pend_x) : 64'sd0);
          void'(vq.pop_back());
          y = 0;
          for (int k = 0; k < NTAP; k++) y += h[k] * vq[k+3];
          m_y   = y;
          m_s   = m_y[25:10];
          m_dev = 32'(longint'(m_s) * longint'(Kd));
          m_pend = en_a;
        end
        if (en_a) begin
          m_x = m_full ? m_hold : m_xprev;
          if (!m_full) m_under = 1;
          m_full   = 0;
          m_xprev  = m_x;
          m_pend_x = m_x;
        end
        if (m_acc) begin
          m_hold = aud_if.audio;
          m_full = 1;
        end
        m_run = 1;
      end
      exp_q.push_back('{ready: m_run && !m_full, under: m_under, rf: m_rf, dev: m_dev});
    end
  end

  // Monitor: compares every clk against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("audio_ready", {31'd0, aud_if.audio_ready}, {31'd0, e.ready});
        cmp("underrun",    {31'd0, underrun},           {31'd0, e.under});
        cmp("rf",          {31'd0, rf},                 {31'd0, e.rf});
        cmp("dev",         dut.r_dev,                   e.dev);
      end
    end
  end

  // Audio producer: valid stays high across back-to-back samples.
  int  mode = 0;
  bit  feed = 0;
  bit  alt  = 0;

  function automatic logic signed [15:0] next_sample();
    logic signed [15:0] v;
    case (mode)
      0:       v = 16'sd0;
      1:       v = 16'sd1000;
      2:       begin alt = ~alt; v = alt ? 16'sh7fff : 16'sh8000; end
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  task automatic send(input logic signed [15:0] s);
    logic r;
    int   n;
    aud_if.audio       = s;
    aud_if.audio_valid = 1'b1;
    n = 0;
    do begin
      r = aud_if.audio_ready;
      @(negedge clk);
      n++;
    end while (!r && n < 4*PER);
    if (!r) cmp("send_timeout", 32'd0, 32'd1);
    else    $display("txn: sample %0d handed over at %0t", s, $time);
  endtask

  initial begin
    aud_if.audio       = '0;
    aud_if.audio_valid = 1'b0;
    @(negedge clk);
    forever begin
      if (feed) send(next_sample());
      else begin
        aud_if.audio_valid = 1'b0;
        @(negedge clk);
      end
    end
  end

  // Directed sequence of operating phases.
  initial begin
    logic signed [31:0] dv;
    int n;
    K = 32'h4000_0000; Kd = 15'd0; mode = 0; feed = 1;
    repeat (5) @(negedge clk);
    cmp("reset_ready", {31'd0, aud_if.audio_ready}, 32'd0);
    cmp("reset_rf",    {31'd0, rf},                 32'd0);
    #2 reset = 1'b1;

    // Carrier only.
    repeat (12*PER) @(negedge clk);
    cmp("carrier_underrun", {31'd0, underrun}, 32'd0);

    // DC gain.
    mode = 1; Kd = 15'd1;
    repeat (10*PER) @(negedge clk);
    cmp("dc_dev_kd1", dut.r_dev, 32'd878);
    Kd = 15'd2;
    repeat (3*PER) @(negedge clk);
    cmp("dc_dev_kd2", dut.r_dev, 32'd1756);

    // Underrun: stop supplying, level must hold.
    feed = 0;
    repeat (4*PER) @(negedge clk);
    cmp("underrun_set", {31'd0, underrun}, 32'd1);
    cmp("underrun_dev", dut.r_dev, 32'd1756);
    feed = 1;
    repeat (2*PER) @(negedge clk);
    cmp("underrun_sticky", {31'd0, underrun}, 32'd1);

    // Full scale with unit gain: dev equals s, bounded by 28800.
    mode = 2; Kd = 15'd1; K = $urandom;
    repeat (8*PER) @(negedge clk);
    for (int i = 0; i < 6*PER; i += 7) begin
      repeat (7) @(negedge clk);
      dv = dut.r_dev;
      cmp("fullscale_bound", {31'd0, (dv > 28800 || dv < -28800)}, 32'd0);
    end
    Kd = 15'($urandom_range(32767, 1));
    repeat (6*PER) @(negedge clk);

    // Reset mid-stream with a sample held.
    mode = 3;
    n = 0;
    while (aud_if.audio_ready && n < 3*PER) begin
      @(negedge clk);
      n++;
    end
    cmp("wait_full", {31'd0, aud_if.audio_ready}, 32'd0);
    #2 reset = 1'b0;
    #1;
    cmp("midreset_ready",    {31'd0, aud_if.audio_ready}, 32'd0);
    cmp("midreset_underrun", {31'd0, underrun},           32'd0);
    cmp("midreset_rf",       {31'd0, rf},                 32'd0);
    cmp("midreset_dev",      dut.r_dev,                   32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    // Random audio, random gains.
    K = $urandom; Kd = 15'($urandom_range(32767, 0));
    repeat (15*PER) @(negedge clk);

    feed = 0;
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
